// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C widths, R/W encoding and target FSM state type
package i2c_pkg;

    localparam int   I2C_ADDR_W  = 7;
    localparam int   I2C_BYTE_W  = 8;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_slv_state_e;

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// rtl/i2c_bus_cond_detect.sv - SCL/SDA synchronisers, SCL edge and START/STOP detection
//
// Ports:
//   clk_i, rst_i   system clock, asynchronous active-low reset
//   scl_i, sda_i   raw asynchronous bus lines
//   sda_s          synchronised SDA level
//   scl_rise       1-cycle strobe on synchronised SCL rise
//   scl_fall       1-cycle strobe on synchronised SCL fall
//   start_det      SDA fell while SCL stayed high
//   stop_det       SDA rose while SCL stayed high
module i2c_bus_cond_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Flops reset to 1 so an idle (pulled-up) bus produces no edges after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SCL must be high in both samples so a data change racing an SCL edge is not a condition.
    assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target engine answering ADDR_COUNT addresses from BASE_ADDR
//
// Ports:
//   clk_i, rst_i          system clock (>= 10x SCL), asynchronous active-low reset
//   scl_i, sda_i          asynchronous bus lines
//   sda_o                 open-drain SDA control (0 = pull low, 1 = release)
//   busy_o                addressed transfer in progress
//   rw_o, addr_idx_o      R/W bit and address offset of the last matched address
//   start_o, stop_o       bus condition pulses
//   rx_data_o/rx_valid_o  received write byte and its strobe; rx_ready_i selects ACK/NACK
//   tx_req_o              request for the next read byte; tx_data_i/tx_valid_i sampled with it
//   tx_underrun_o         pulse when tx_valid_i was low and 8'hFF is sent instead
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] BASE_ADDR   = 7'h44,
    parameter int                    ADDR_COUNT  = 1,
    parameter int                    SYNC_STAGES = 2,
    localparam int IDX_W = (ADDR_COUNT > 1) ? $clog2(ADDR_COUNT) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  rw_o,
    output logic [IDX_W-1:0]      addr_idx_o,
    output logic                  start_o,
    output logic                  stop_o,
    output logic [I2C_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  tx_req_o,
    input  logic [I2C_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_underrun_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_cond_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_slv_state_e        state;
    logic [I2C_BYTE_W-1:0] shift_reg;
    logic [2:0]            bit_cnt;
    logic                  ack_phase;    // 0: next fall starts the ACK slot, 1: next fall ends it
    logic                  ack_ok;       // rx_ready_i captured in the rx_valid_o cycle
    logic                  master_nack;  // SDA level sampled on the read ACK rise

    logic [I2C_BYTE_W-1:0] byte_in;
    logic [7:0]            addr_off;
    logic                  addr_hit;
    logic [I2C_BYTE_W-1:0] tx_byte;

    assign byte_in  = {shift_reg[6:0], sda_s};
    // Addresses below BASE_ADDR wrap to large offsets, so one compare covers both bounds.
    assign addr_off = {1'b0, byte_in[7:1]} - {1'b0, BASE_ADDR};
    assign addr_hit = (addr_off < 8'(ADDR_COUNT));
    assign tx_byte  = tx_valid_i ? tx_data_i : 8'hFF;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ST_IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            ack_phase     <= 1'b0;
            ack_ok        <= 1'b0;
            master_nack   <= 1'b0;
            sda_o         <= 1'b1;
            busy_o        <= 1'b0;
            rw_o          <= 1'b0;
            addr_idx_o    <= '0;
            start_o       <= 1'b0;
            stop_o        <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            tx_req_o      <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            start_o       <= 1'b0;
            stop_o        <= 1'b0;
            rx_valid_o    <= 1'b0;
            tx_req_o      <= 1'b0;
            tx_underrun_o <= 1'b0;

            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_o     <= 1'b1;
                busy_o    <= 1'b0;
                start_o   <= 1'b1;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                ack_phase <= 1'b0;
                sda_o     <= 1'b1;
                busy_o    <= 1'b0;
                stop_o    <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (addr_hit) begin
                                    rw_o       <= byte_in[0];
                                    addr_idx_o <= addr_off[IDX_W-1:0];
                                    busy_o     <= 1'b1;
                                    state      <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_o     <= 1'b0;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                if (rw_o == I2C_RW_READ) begin
                                    // SDA stays low one more cycle until the byte is loaded.
                                    state    <= ST_RD_DATA;
                                    tx_req_o <= 1'b1;
                                end else begin
                                    state <= ST_WR_DATA;
                                    sda_o <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= byte_in;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data_o  <= byte_in;
                                rx_valid_o <= 1'b1;
                                state      <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (rx_valid_o) begin
                            ack_ok <= rx_ready_i;
                        end
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_o     <= ~ack_ok;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                sda_o     <= 1'b1;
                                state     <= ack_ok ? ST_WR_DATA : ST_IGNORE;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (tx_req_o) begin
                            // Request cycle: capture the byte and put its MSB on the bus.
                            sda_o         <= tx_byte[7];
                            shift_reg     <= {tx_byte[6:0], 1'b1};
                            tx_underrun_o <= ~tx_valid_i;
                            bit_cnt       <= '0;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_o   <= 1'b1;
                                bit_cnt <= '0;
                                state   <= ST_RD_ACK;
                            end else begin
                                sda_o     <= shift_reg[7];
                                shift_reg <= {shift_reg[6:0], 1'b1};
                                bit_cnt   <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s;
                        end
                        if (scl_fall) begin
                            if (master_nack) begin
                                state <= ST_IGNORE;
                            end else begin
                                state    <= ST_RD_DATA;
                                tx_req_o <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
